mips_cpu_bus: RTL and testbench
===============================

// Module: mips_cpu_bus
// PURPOSE
// - Multicycle MIPS-I (32-bit) integer CPU core with one unified, Avalon-style memory bus for instructions and data.
// - Top-level CPU block: it fetches from the reset vector, runs until it jumps to address 0, then halts.
// - Exposes $v0 (r2) so system benches can check the program result.
// PARAMETERS
// - RESET_VECTOR  32'hBFC0_0000  first fetch address after reset
// PORTS
// - clk          in   1   clock; all state updates on the rising edge
// - reset        in   1   reset, asynchronous, active-high
// - active       out  1   1 while running; 0 once halted
// - register_v0  out  32  live contents of GPR r2
// - address      out  32  byte address of the bus access
// - write        out  1   write strobe
// - read         out  1   read strobe
// - waitrequest  in   1   1 = slave stalls the current request
// - writedata    out  32  store data, lane-aligned
// - byteenable   out  4   byte lanes; bit k = bits [8k+7:8k]
// - readdata     in   32  read data, valid on the cycle after the accepted request
// BEHAVIOUR
// - Reset: PC=RESET_VECTOR, all GPRs=0, active=1, read=0, write=0, byteenable=0, state=FETCH.
// - Bus byte order: little-endian. The byte at (word address + k) uses lane k (readdata/writedata[8k+7:8k], byteenable[k]).
// - A request is accepted on the rising edge where read|write=1 and waitrequest=0.
//   - While waitrequest=1, hold address, read, write, writedata and byteenable stable.
//   - Treat waitrequest=X/Z as 0.
// - Read data is sampled on the edge after acceptance. Only enabled lanes are defined.
// - Only one of read/write may be high at a time. Address is always word-aligned (addr[1:0]=00); byteenable selects the lanes.
// - FSM: FETCH -> DECODE/EXEC -> (MEM) -> WRITEBACK -> FETCH.
//   - FETCH: read=1, address=PC, byteenable=4'b1111.
//   - MEM: loads and stores only.
// - Halt: when the PC reaches 0 at FETCH, set active=0, issue no bus access, and stay halted until reset.
//   - A halt is normally reached via `jr $0` after its delay slot.
// - Branch/jump delay slot: always execute the instruction after a branch or jump.
//   - Branch target = PC+4 + (sign-extended imm << 2).
//   - J/JAL target = {PC+4[31:28], idx, 2'b00}.
//   - JAL/JALR write PC+8 to the link register.
// - Instructions:
//   - ALU: ADDU ADDIU SUBU AND OR XOR NOR ANDI ORI XORI LUI SLT SLTU SLTI SLTIU SLL SRL SRA SLLV SRLV SRAV.
//   - Branch/jump: BEQ BNE BLEZ BGTZ BLTZ BGEZ J JAL JR JALR.
//   - Memory: LB LBU LH LHU LW SB SH SW.
// - Immediates: sign-extended, except for ANDI/ORI/XORI (zero-extended). Arithmetic wraps mod 2^32; there are no overflow traps.
// - Loads: LB/LH sign-extend the selected lane(s); LBU/LHU zero-extend.
//   - Byte access: lane = addr[1:0]. Halfword access: lanes addr[1]?{3,2}:{1,0}.
// - Stores: replicate the data into the target lane(s) and enable only those lanes.
// - Writes to r0 are discarded; r0 always reads as 0.
// - Unaligned or unknown opcodes execute as NOP.
// - Reset mid-access drops the request immediately (asynchronous); fetch restarts at RESET_VECTOR.
// TESTING
// - After reset release: the first cycle has active=1, read=1, address=BFC00000, byteenable=1111, write=0.
// - LBU: a byte 0x03 in lane 2 at BFC00100, then `lbu $2,0x102($base)`, then `jr $0` -> halt with active=0 and register_v0=3.
// - LB: byte 0x83 -> v0=FFFFFF83. LBU of the same byte -> v0=00000083. LH/LHU of 0x8001 behave the same way (sign vs zero extension).
// - SB $t(=0x12345678) to addr+1 -> write=1, byteenable=0010, writedata[15:8]=78. Reading the word back shows only lane 1 changed.
// - Hold waitrequest=1 for 3 cycles during a fetch -> bus outputs stay stable, the result is unchanged and finishes 3 cycles later.
// - `jal` then `addiu $2,$0,5` in the delay slot -> the delay slot executes, ra=PC+8, final v0=5.

Source files
------------

// File: rtl/mips_cpu_bus.sv
// Multicycle MIPS-I core on a single Avalon-style bus.
// Runs from RESET_VECTOR until it jumps to 0, then halts.
module mips_cpu_bus #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, npc, ir;
    logic [31:0] gpr [0:31];

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sa, widx;
    logic [31:0] a, b, simm, zimm, pc4, maddr;
    logic [31:0] y, tgt, ldv, mwd;
    logic [7:0]  lbyte;
    logic [15:0] lhalf;
    logic [3:0]  mbe;
    logic        wen, ld, st, jmp, acc;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign sa    = ir[10:6];
    assign fn    = ir[5:0];
    assign simm  = {{16{ir[15]}}, ir[15:0]};
    assign zimm  = {16'h0, ir[15:0]};
    assign a     = gpr[rs];
    assign b     = gpr[rt];
    assign pc4   = pc + 32'd4;
    assign maddr = a + simm;
    assign acc   = !(waitrequest === 1'b1);
    assign register_v0 = gpr[2];

    // Decode stays valid from EXEC through WB: ir and GPRs are stable.
    always_comb begin
        y = 32'h0; wen = 1'b0; widx = rd;
        ld = 1'b0; st = 1'b0; jmp = 1'b0;
        tgt = pc4 + {simm[29:0], 2'b00};
        case (op)
            6'h00: begin
                wen = 1'b1;
                case (fn)
                    6'h00: y = b << sa;
                    6'h02: y = b >> sa;
                    6'h03: y = $signed(b) >>> sa;
                    6'h04: y = b << a[4:0];
                    6'h06: y = b >> a[4:0];
                    6'h07: y = $signed(b) >>> a[4:0];
                    6'h08: begin wen = 1'b0; jmp = 1'b1; tgt = a; end
                    6'h09: begin jmp = 1'b1; tgt = a; y = pc + 32'd8; end
                    6'h21: y = a + b;
                    6'h23: y = a - b;
                    6'h24: y = a & b;
                    6'h25: y = a | b;
                    6'h26: y = a ^ b;
                    6'h27: y = ~(a | b);
                    6'h2A: y = {31'h0, $signed(a) < $signed(b)};
                    6'h2B: y = {31'h0, a < b};
                    default: wen = 1'b0;
                endcase
            end
            6'h01: begin
                if (rt == 5'd0) jmp = a[31];
                if (rt == 5'd1) jmp = !a[31];
            end
            6'h02: begin
                jmp = 1'b1;
                tgt = {pc4[31:28], ir[25:0], 2'b00};
            end
            6'h03: begin
                jmp = 1'b1; wen = 1'b1; widx = 5'd31;
                tgt = {pc4[31:28], ir[25:0], 2'b00};
                y = pc + 32'd8;
            end
            6'h04: jmp = (a == b);
            6'h05: jmp = (a != b);
            6'h06: jmp = a[31] || (a == 32'h0);
            6'h07: jmp = !a[31] && (a != 32'h0);
            6'h09: begin wen = 1'b1; widx = rt; y = a + simm; end
            6'h0A: begin
                wen = 1'b1; widx = rt;
                y = {31'h0, $signed(a) < $signed(simm)};
            end
            6'h0B: begin wen = 1'b1; widx = rt; y = {31'h0, a < simm}; end
            6'h0C: begin wen = 1'b1; widx = rt; y = a & zimm; end
            6'h0D: begin wen = 1'b1; widx = rt; y = a | zimm; end
            6'h0E: begin wen = 1'b1; widx = rt; y = a ^ zimm; end
            6'h0F: begin wen = 1'b1; widx = rt; y = {ir[15:0], 16'h0}; end
            6'h20, 6'h24: ld = 1'b1;
            6'h21, 6'h25: ld = !maddr[0];
            6'h23: ld = (maddr[1:0] == 2'b00);
            6'h28: st = 1'b1;
            6'h29: st = !maddr[0];
            6'h2B: st = (maddr[1:0] == 2'b00);
            default: ;
        endcase
        if (ld) begin
            wen = 1'b1;
            widx = rt;
        end
    end

    always_comb begin
        lbyte = readdata[{maddr[1:0], 3'b000} +: 8];
        lhalf = maddr[1] ? readdata[31:16] : readdata[15:0];
        case (op)
            6'h20: ldv = {{24{lbyte[7]}}, lbyte};
            6'h24: ldv = {24'h0, lbyte};
            6'h21: ldv = {{16{lhalf[15]}}, lhalf};
            6'h25: ldv = {16'h0, lhalf};
            default: ldv = readdata;
        endcase
        case (op)
            6'h28: begin
                mwd = {4{b[7:0]}};
                mbe = 4'b0001 << maddr[1:0];
            end
            6'h29: begin
                mwd = {2{b[15:0]}};
                mbe = maddr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                mwd = b;
                mbe = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_n    = state;
        active     = 1'b1;
        read       = 1'b0;
        write      = 1'b0;
        address    = pc;
        byteenable = 4'b0000;
        writedata  = 32'h0;
        case (state)
            FETCH: begin
                if (pc == 32'h0) begin
                    active  = 1'b0;
                    state_n = HALT;
                end else begin
                    read       = 1'b1;
                    byteenable = 4'b1111;
                    if (acc) state_n = DECODE;
                end
            end
            DECODE: state_n = EXEC;
            EXEC:   state_n = (ld || st) ? MEM : WB;
            MEM: begin
                address    = {maddr[31:2], 2'b00};
                read       = ld;
                write      = st;
                byteenable = mbe;
                writedata  = st ? mwd : 32'h0;
                if (acc) state_n = WB;
            end
            WB:     state_n = FETCH;
            HALT:   active = 1'b0;
            default: state_n = FETCH;
        endcase
        if (reset) begin
            read       = 1'b0;
            write      = 1'b0;
            byteenable = 4'b0000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_VECTOR;
            npc   <= RESET_VECTOR + 32'd4;
            ir    <= 32'h0;
            for (int i = 0; i < 32; i++) gpr[i] <= 32'h0;
        end else begin
            state <= state_n;
            if (state == DECODE) ir <= readdata;
            if (state == WB) begin
                if (wen && widx != 5'd0)
                    gpr[widx] <= ld ? ldv : y;
                pc  <= npc;
                npc <= jmp ? tgt : npc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Directed program bench for mips_cpu_bus.
// Small programs run from a word memory; v0 and bus checked.
module tb_mips_cpu_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    mips_cpu_bus dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [31:0]      data;
        logic [31:0]      exp;
        logic [9:0][31:0] prog;
    } vec_t;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] JR0  = 32'h0000_0008;
    localparam logic [31:0] BAD  = 32'hFC00_0000;
    localparam logic [31:0] JALW3 = {6'h03, 26'h3F0_0003};

    vec_t        vecs [24];
    int          n_vec = 0;
    logic [31:0] mem [256];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          seen_wr;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_be;

    function automatic logic [31:0] ii(int o, int s, int t, int i);
        return {o[5:0], s[4:0], t[4:0], i[15:0]};
    endfunction

    function automatic logic [31:0] rr(int s, int t, int d, int h, int f);
        return {6'h00, s[4:0], t[4:0], d[4:0], h[4:0], f[5:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic addv(input string nm, input logic [31:0] d,
                        input logic [31:0] e,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input logic [31:0] p2 = 0, input logic [31:0] p3 = 0,
                        input logic [31:0] p4 = 0, input logic [31:0] p5 = 0,
                        input logic [31:0] p6 = 0, input logic [31:0] p7 = 0,
                        input logic [31:0] p8 = 0, input logic [31:0] p9 = 0);
        vec_t v;
        v.name = nm;
        v.data = d;
        v.exp  = e;
        v.prog = {p9, p8, p7, p6, p5, p4, p3, p2, p1, p0};
        vecs[n_vec] = v;
        n_vec++;
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 10; i++) mem[i] = v.prog[i];
        mem[64] = v.data;
    endtask

    // Runs from reset to halt; stalls the first stall_len cycles.
    task automatic run(input int stall_len, output int cyc);
        reset = 1'b1;
        waitrequest = 1'b0;
        seen_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        cyc = 0;
        while (active && cyc < 400) begin
            waitrequest = (cyc < stall_len);
            if (cyc < stall_len) begin
                chk("stall_addr", address, 32'hBFC0_0000);
                chk("stall_ctl", {28'h0, read, write, byteenable[1:0]},
                    32'h0000_000B);
            end
            if (read && !waitrequest)
                readdata = mem[address[9:2]];
            if (write && !waitrequest) begin
                if (!seen_wr) begin
                    seen_wr = 1'b1;
                    wr_addr = address;
                    wr_data = writedata;
                    wr_be   = byteenable;
                end
                for (int k = 0; k < 4; k++)
                    if (byteenable[k])
                        mem[address[9:2]][8*k +: 8] = writedata[8*k +: 8];
            end
            @(negedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 400) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: active still %b after %0d cycles",
                     active, cyc);
        end
    endtask

    logic [31:0] LUI8;
    int          c0, c1, sb_i;

    initial begin
        LUI8 = ii(6'h0F, 0, 8, 16'hBFC0);
        addv("lbu", 32'h0003_0000, 32'h3,
             LUI8, ii(6'h24, 8, 2, 16'h0102), JR0, NOP);
        addv("lb", 32'h0083_0000, 32'hFFFF_FF83,
             LUI8, ii(6'h20, 8, 2, 16'h0102), JR0, NOP);
        addv("lbu83", 32'h0083_0000, 32'h0000_0083,
             LUI8, ii(6'h24, 8, 2, 16'h0102), JR0, NOP);
        addv("lh", 32'h8001_0000, 32'hFFFF_8001,
             LUI8, ii(6'h21, 8, 2, 16'h0102), JR0, NOP);
        addv("lhu", 32'h8001_0000, 32'h0000_8001,
             LUI8, ii(6'h25, 8, 2, 16'h0102), JR0, NOP);
        addv("lw", 32'hDEAD_BEEF, 32'hDEAD_BEEF,
             LUI8, ii(6'h23, 8, 2, 16'h0100), JR0, NOP);
        addv("addu_subu", 0, 32'hFFFF_FFFF,
             ii(6'h09, 0, 3, 16'hFFFF), ii(6'h09, 0, 4, 2),
             rr(3, 4, 5, 0, 6'h21), rr(5, 4, 2, 0, 6'h23), JR0, NOP);
        addv("or_nor", 0, 32'h0000_0F0F,
             ii(6'h0D, 0, 3, 16'hF0F0), ii(6'h0F, 0, 4, 16'hFFFF),
             rr(3, 4, 5, 0, 6'h25), rr(5, 0, 2, 0, 6'h27), JR0, NOP);
        addv("xori_zext", 0, 32'hFFFF_0000,
             ii(6'h09, 0, 3, 16'hFFFF), ii(6'h0E, 3, 2, 16'hFFFF), JR0, NOP);
        addv("sra_srl", 0, 32'hF000_0000,
             ii(6'h0F, 0, 3, 16'h8000), rr(0, 3, 4, 4, 6'h03),
             rr(0, 3, 5, 4, 6'h02), rr(4, 5, 2, 0, 6'h26), JR0, NOP);
        addv("sllv", 0, 32'h0000_0010,
             ii(6'h09, 0, 3, 1), ii(6'h09, 0, 4, 4),
             rr(4, 3, 2, 0, 6'h04), JR0, NOP);
        addv("slt", 0, 32'h0000_0003,
             ii(6'h09, 0, 3, 16'hFFFF), rr(3, 0, 4, 0, 6'h2A),
             rr(3, 0, 5, 0, 6'h2B), ii(6'h0B, 0, 6, 1),
             rr(0, 4, 4, 1, 6'h00), rr(4, 5, 4, 0, 6'h25),
             rr(4, 6, 2, 0, 6'h21), JR0, NOP);
        addv("beq_slot", 0, 32'h0000_0007,
             ii(6'h09, 0, 2, 1), ii(6'h04, 0, 0, 2),
             ii(6'h09, 2, 2, 2), ii(6'h09, 2, 2, 100),
             ii(6'h09, 2, 2, 4), JR0, NOP);
        addv("bne_not", 0, 32'h0000_0003,
             ii(6'h09, 0, 3, 5), ii(6'h05, 3, 3, 2),
             ii(6'h09, 0, 2, 1), ii(6'h09, 2, 2, 2), JR0, NOP);
        addv("bgez_bltz", 0, 32'h0000_000B,
             ii(6'h09, 0, 3, 16'hFFFF), ii(6'h01, 3, 1, 2),
             ii(6'h09, 0, 2, 1), ii(6'h01, 3, 0, 2),
             ii(6'h09, 2, 2, 2), ii(6'h09, 2, 2, 100),
             ii(6'h09, 2, 2, 8), JR0, NOP);
        addv("jal_slot", 0, 32'h0000_0005,
             JALW3, ii(6'h09, 0, 2, 5), ii(6'h09, 0, 2, 99), JR0, NOP);
        addv("jal_ra", 0, 32'hBFC0_0008,
             JALW3, NOP, NOP, rr(31, 0, 2, 0, 6'h21), JR0, NOP);
        sb_i = n_vec;
        addv("sb_readback", 32'hAABB_CCDD, 32'hAABB_78DD,
             LUI8, ii(6'h0F, 0, 9, 16'h1234), ii(6'h0D, 9, 9, 16'h5678),
             ii(6'h28, 8, 9, 16'h0101), ii(6'h23, 8, 2, 16'h0100),
             JR0, NOP);
        addv("sh_readback", 32'hAABB_CCDD, 32'h5678_CCDD,
             LUI8, ii(6'h0F, 0, 9, 16'h1234), ii(6'h0D, 9, 9, 16'h5678),
             ii(6'h29, 8, 9, 16'h0102), ii(6'h23, 8, 2, 16'h0100),
             JR0, NOP);
        addv("r0_discard", 0, 32'h0000_0009,
             ii(6'h09, 0, 2, 9), ii(6'h09, 0, 0, 5),
             rr(2, 0, 2, 0, 6'h21), JR0, NOP);
        addv("nop_ops", 32'h1111_1111, 32'h0000_0007,
             LUI8, ii(6'h09, 0, 2, 7), ii(6'h23, 8, 2, 16'h0101),
             BAD, JR0, NOP);

        reset = 1'b1;
        waitrequest = 1'b0;
        readdata = 32'h0;
        #7;
        chk("rst_read", {31'h0, read}, 32'h0);
        chk("rst_write", {31'h0, write}, 32'h0);
        chk("rst_be", {28'h0, byteenable}, 32'h0);
        chk("rst_active", {31'h0, active}, 32'h1);
        chk("rst_v0", register_v0, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("first_addr", address, 32'hBFC0_0000);
        chk("first_ctl", {27'h0, active, read, write, byteenable[1:0]},
            32'h0000_001B);
        chk("first_be", {28'h0, byteenable}, 32'hF);

        waitrequest = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_read", {31'h0, read}, 32'h0);

        for (int i = 0; i < n_vec; i++) begin
            load(vecs[i]);
            run(0, c0);
            chk(vecs[i].name, register_v0, vecs[i].exp);
        end

        load(vecs[sb_i]);
        run(0, c0);
        chk("sb_seen", {31'h0, seen_wr}, 32'h1);
        chk("sb_addr", wr_addr, 32'hBFC0_0100);
        chk("sb_be", {28'h0, wr_be}, 32'h2);
        chk("sb_lane1", {24'h0, wr_data[15:8]}, 32'h78);

        load(vecs[0]);
        run(0, c0);
        run(3, c1);
        chk("stall_v0", register_v0, 32'h3);
        chk("stall_cycles", c1, c0 + 3);
        chk("halt_active", {31'h0, active}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
